// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Minimal AXI definitions shared by the ID remapper and its environment.
//   ATOP_R_RESP : bit of aw.atop that marks an atomic which also returns R data.
//   slv_*       : upstream channel/bundle types (4-bit IDs).
//   mst_*       : downstream channel/bundle types (2-bit IDs).
//   w_chan_t    : W channel, identical on both sides (W carries no ID).
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam int unsigned ATOP_R_RESP = 5;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } slv_aw_chan_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
    } mst_aw_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } slv_ar_chan_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } mst_ar_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } slv_b_chan_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } mst_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } slv_r_chan_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } mst_r_chan_t;

    typedef struct packed {
        slv_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        slv_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } slv_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        slv_b_chan_t b;
        logic        b_valid;
        slv_r_chan_t r;
        logic        r_valid;
    } slv_rsp_t;

    typedef struct packed {
        mst_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        mst_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } mst_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        mst_b_chan_t b;
        logic        b_valid;
        mst_r_chan_t r;
        logic        r_valid;
    } mst_rsp_t;

endpackage

// File: rtl/axi_id_remap_slot_table.sv
// -----------------------------------------------------------------------------
// axi_id_remap_slot_table
// One direction's ID binding table: 2**IdxWidth slots of {busy, in_id, cnt}.
// Optional assertions compiled in with `define AXI_ID_REMAP_ASSERT_EN.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   lookup_id      : upstream ID being allocated this cycle
//   hit_vec        : slot is busy and bound to lookup_id
//   avail_vec      : hit and still below MaxTxns outstanding
//   free_vec       : slot is not busy
//   alloc_ok/idx   : ordinary allocation result (hit slot, else lowest free)
//   push/push_idx/push_id : request handshake on a slot (cnt+1, bind ID)
//   pop/pop_idx    : response completion on a slot (cnt-1)
//   resp_idx       : downstream ID of a response beat
//   resp_in_id     : upstream ID bound to resp_idx
// -----------------------------------------------------------------------------
module axi_id_remap_slot_table #(
    parameter int unsigned IdxWidth  = 2,
    parameter int unsigned InIdWidth = 4,
    parameter int unsigned MaxTxns   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [InIdWidth-1:0]  lookup_id,
    output logic [2**IdxWidth-1:0] hit_vec,
    output logic [2**IdxWidth-1:0] avail_vec,
    output logic [2**IdxWidth-1:0] free_vec,
    output logic                  alloc_ok,
    output logic [IdxWidth-1:0]   alloc_idx,
    input  logic                  push,
    input  logic [IdxWidth-1:0]   push_idx,
    input  logic [InIdWidth-1:0]  push_id,
    input  logic                  pop,
    input  logic [IdxWidth-1:0]   pop_idx,
    input  logic [IdxWidth-1:0]   resp_idx,
    output logic [InIdWidth-1:0]  resp_in_id
);

    localparam int unsigned NumSlots = 2**IdxWidth;
    localparam int unsigned CntWidth = $clog2(MaxTxns + 1);

    typedef struct packed {
        logic                 busy;
        logic [InIdWidth-1:0] in_id;
        logic [CntWidth-1:0]  cnt;
    } slot_t;

    slot_t slots [NumSlots];

    logic [NumSlots-1:0] inc_vec;
    logic [NumSlots-1:0] dec_vec;
    logic [IdxWidth-1:0] hit_idx;
    logic [IdxWidth-1:0] free_idx;

    always_comb begin
        hit_vec   = '0;
        avail_vec = '0;
        free_vec  = '0;
        inc_vec   = '0;
        dec_vec   = '0;
        hit_idx   = '0;
        free_idx  = '0;
        for (int i = 0; i < NumSlots; i++) begin
            hit_vec[i]   = slots[i].busy && (slots[i].in_id == lookup_id);
            avail_vec[i] = hit_vec[i] && (slots[i].cnt < CntWidth'(MaxTxns));
            free_vec[i]  = !slots[i].busy;
            inc_vec[i]   = push && (push_idx == IdxWidth'(i));
            dec_vec[i]   = pop && (pop_idx == IdxWidth'(i));
        end
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (hit_vec[i])  hit_idx  = IdxWidth'(i);
            if (free_vec[i]) free_idx = IdxWidth'(i);
        end
        // A bound ID must keep its slot to preserve ordering, even when full.
        if (|hit_vec) begin
            alloc_ok  = |avail_vec;
            alloc_idx = hit_idx;
        end else begin
            alloc_ok  = |free_vec;
            alloc_idx = free_idx;
        end
        resp_in_id = slots[resp_idx].in_id;
    end

    // NOTE: the table is a handful of flops, not a RAM, and busy must read 0
    // straight out of reset, so every slot is cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumSlots; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10: begin
                        slots[i].busy  <= 1'b1;
                        slots[i].in_id <= push_id;
                        slots[i].cnt   <= slots[i].cnt + CntWidth'(1);
                    end
                    2'b01: begin
                        slots[i].cnt  <= slots[i].cnt - CntWidth'(1);
                        slots[i].busy <= (slots[i].cnt != CntWidth'(1));
                    end
                    // Push and pop together leave the count and binding as is.
                    default: ;
                endcase
            end
        end
    end

`ifdef AXI_ID_REMAP_ASSERT_EN
    pop_on_idle_slot: assert property (@(posedge clk) disable iff (rst)
        pop |-> slots[pop_idx].busy)
        else $error("response for idle slot %0d", pop_idx);

    cnt_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !(pop && pop_idx == push_idx)) |-> (slots[push_idx].cnt < CntWidth'(MaxTxns)))
        else $error("counter overflow on slot %0d", push_idx);

    cnt_underflow: assert property (@(posedge clk) disable iff (rst)
        (pop && !(push && push_idx == pop_idx)) |-> (slots[pop_idx].cnt != '0))
        else $error("counter underflow on slot %0d", pop_idx);
`endif

endmodule

// File: rtl/axi_id_remap_table_ctrl.sv
// -----------------------------------------------------------------------------
// axi_id_remap_table_ctrl
// Remaps wide upstream AXI IDs onto 2**AxiOutIdWidth downstream IDs and
// restores the original ID on every B and R beat. An upstream ID stays bound
// to one downstream ID while it has transactions outstanding.
// Optional assertions compiled in with `define AXI_ID_REMAP_ASSERT_EN.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   slv_req_i    : upstream request (wide IDs)
//   slv_rsp_o    : upstream response (B/R IDs restored)
//   mst_req_o    : downstream request (AW/AR IDs = slot index)
//   mst_rsp_i    : downstream response
// -----------------------------------------------------------------------------
module axi_id_remap_table_ctrl #(
    parameter int unsigned AxiInIdWidth  = 4,
    parameter int unsigned AxiOutIdWidth = 2,
    parameter int unsigned MaxTxnsPerId  = 4,
    parameter type slv_req_t = axi_pkg::slv_req_t,
    parameter type slv_rsp_t = axi_pkg::slv_rsp_t,
    parameter type mst_req_t = axi_pkg::mst_req_t,
    parameter type mst_rsp_t = axi_pkg::mst_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  slv_req_t slv_req_i,
    output slv_rsp_t slv_rsp_o,
    output mst_req_t mst_req_o,
    input  mst_rsp_t mst_rsp_i
);

    localparam int unsigned NumOutIds = 2**AxiOutIdWidth;

    logic [NumOutIds-1:0]     wr_hit, wr_avail, wr_free;
    logic [NumOutIds-1:0]     rd_hit, rd_avail, rd_free;
    logic                     wr_alloc_ok, rd_alloc_ok;
    logic [AxiOutIdWidth-1:0] wr_alloc_idx, rd_alloc_idx;
    logic [AxiInIdWidth-1:0]  rd_lookup_id, wr_b_in_id, rd_r_in_id;

    logic                     atop_rresp, atop_pending;
    logic [NumOutIds-1:0]     joint_vec;
    logic                     joint_ok;
    logic [AxiOutIdWidth-1:0] joint_idx;
    logic                     aw_ok, ar_ok;
    logic [AxiOutIdWidth-1:0] aw_idx;
    logic                     aw_hs, ar_hs, b_hs, r_last_hs;
    logic                     rd_push;
    logic [AxiOutIdWidth-1:0] rd_push_idx;

    always_comb begin
        atop_rresp   = slv_req_i.aw.atop[axi_pkg::ATOP_R_RESP];
        atop_pending = slv_req_i.aw_valid && atop_rresp;
        // While an R-returning atomic is presented, the read table is looked
        // up with its ID and plain ARs wait, so the read table sees one push.
        rd_lookup_id = atop_pending ? slv_req_i.aw.id : slv_req_i.ar.id;

        // Joint slot for atomics: a hit in either table pins the index, so it
        // must be usable in both; otherwise take the lowest index free in both.
        joint_vec = (|wr_hit || |rd_hit) ? (wr_avail & rd_avail) : (wr_free & rd_free);
        joint_ok  = |joint_vec;
        joint_idx = '0;
        for (int i = int'(NumOutIds) - 1; i >= 0; i--) begin
            if (joint_vec[i]) joint_idx = AxiOutIdWidth'(i);
        end

        aw_ok  = atop_rresp ? joint_ok  : wr_alloc_ok;
        aw_idx = atop_rresp ? joint_idx : wr_alloc_idx;
        ar_ok  = rd_alloc_ok && !atop_pending;

        aw_hs     = !rst_i && slv_req_i.aw_valid && aw_ok && mst_rsp_i.aw_ready;
        ar_hs     = !rst_i && slv_req_i.ar_valid && ar_ok && mst_rsp_i.ar_ready;
        b_hs      = mst_rsp_i.b_valid && slv_req_i.b_ready;
        r_last_hs = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;

        rd_push     = ar_hs || (aw_hs && atop_rresp);
        rd_push_idx = ar_hs ? rd_alloc_idx : aw_idx;
    end

    // NOTE: both output structs get a full default before field assignment so
    // no field is left unassigned on any path (which would infer a latch).
    always_comb begin
        mst_req_o = '0;
        slv_rsp_o = '0;

        mst_req_o.aw.id    = aw_idx;
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.len   = slv_req_i.aw.len;
        mst_req_o.aw.atop  = slv_req_i.aw.atop;
        mst_req_o.aw_valid = !rst_i && slv_req_i.aw_valid && aw_ok;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = !rst_i && slv_req_i.b_ready;
        mst_req_o.ar.id    = rd_alloc_idx;
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.len   = slv_req_i.ar.len;
        mst_req_o.ar_valid = !rst_i && slv_req_i.ar_valid && ar_ok;
        mst_req_o.r_ready  = !rst_i && slv_req_i.r_ready;

        slv_rsp_o.aw_ready = !rst_i && aw_ok && mst_rsp_i.aw_ready;
        slv_rsp_o.ar_ready = !rst_i && ar_ok && mst_rsp_i.ar_ready;
        slv_rsp_o.w_ready  = mst_rsp_i.w_ready;
        slv_rsp_o.b.id     = wr_b_in_id;
        slv_rsp_o.b.resp   = mst_rsp_i.b.resp;
        slv_rsp_o.b_valid  = !rst_i && mst_rsp_i.b_valid;
        slv_rsp_o.r.id     = rd_r_in_id;
        slv_rsp_o.r.data   = mst_rsp_i.r.data;
        slv_rsp_o.r.resp   = mst_rsp_i.r.resp;
        slv_rsp_o.r.last   = mst_rsp_i.r.last;
        slv_rsp_o.r_valid  = !rst_i && mst_rsp_i.r_valid;
    end

    axi_id_remap_slot_table #(
        .IdxWidth  (AxiOutIdWidth),
        .InIdWidth (AxiInIdWidth),
        .MaxTxns   (MaxTxnsPerId)
    ) u_wr_table (
        .clk        (clk_i),
        .rst        (rst_i),
        .lookup_id  (slv_req_i.aw.id),
        .hit_vec    (wr_hit),
        .avail_vec  (wr_avail),
        .free_vec   (wr_free),
        .alloc_ok   (wr_alloc_ok),
        .alloc_idx  (wr_alloc_idx),
        .push       (aw_hs),
        .push_idx   (aw_idx),
        .push_id    (slv_req_i.aw.id),
        .pop        (b_hs),
        .pop_idx    (mst_rsp_i.b.id),
        .resp_idx   (mst_rsp_i.b.id),
        .resp_in_id (wr_b_in_id)
    );

    axi_id_remap_slot_table #(
        .IdxWidth  (AxiOutIdWidth),
        .InIdWidth (AxiInIdWidth),
        .MaxTxns   (MaxTxnsPerId)
    ) u_rd_table (
        .clk        (clk_i),
        .rst        (rst_i),
        .lookup_id  (rd_lookup_id),
        .hit_vec    (rd_hit),
        .avail_vec  (rd_avail),
        .free_vec   (rd_free),
        .alloc_ok   (rd_alloc_ok),
        .alloc_idx  (rd_alloc_idx),
        .push       (rd_push),
        .push_idx   (rd_push_idx),
        .push_id    (rd_lookup_id),
        .pop        (r_last_hs),
        .pop_idx    (mst_rsp_i.r.id),
        .resp_idx   (mst_rsp_i.r.id),
        .resp_in_id (rd_r_in_id)
    );

`ifdef AXI_ID_REMAP_ASSERT_EN
    aw_id_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (slv_req_i.aw_valid && !slv_rsp_o.aw_ready)
        |=> (!slv_req_i.aw_valid || $stable(slv_req_i.aw.id)))
        else $error("upstream AW id changed while stalled");

    ar_id_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (slv_req_i.ar_valid && !slv_rsp_o.ar_ready)
        |=> (!slv_req_i.ar_valid || $stable(slv_req_i.ar.id)))
        else $error("upstream AR id changed while stalled");
`endif

endmodule
